// File: rtl/alu_sequencer.sv
// Upstream sequencer for the 8-bit ALU: accepts one decode request at a time, drives the ALU
// handshake, captures flags and issues a register-file writeback.
module alu_sequencer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5,
  parameter logic [7:0]  NOP_OP  = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [1:0] req_dst,
  input  logic       req_wb,
  output logic       alu_start,
  output logic [7:0] alu_cins,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_oe,
  output logic       alu_carryin,
  input  logic       alu_done,
  input  logic [7:0] alu_out,
  input  logic       alu_carryout,
  input  logic       alu_overout,
  input  logic       alu_cmpo,
  output logic       wb_valid,
  output logic [1:0] wb_dst,
  output logic [7:0] wb_data,
  output logic       flag_c,
  output logic       flag_v,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_cmp,
  output logic       err_timeout
);

  localparam logic [7:0] CMP_CLR_OP = 8'h50;

  typedef enum logic [2:0] {
    S_IDLE, S_MODE, S_SETTLE, S_START, S_WAIT_LO, S_WAIT_HI, S_CAPTURE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       op_q, op_d, a_q, a_d, b_q, b_d;
  logic [1:0]       dst_q, dst_d;
  logic             wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             cmp_seen_q, cmp_seen_d;
  logic             req_ready_q, req_ready_d, alu_start_q, alu_start_d, alu_oe_q, alu_oe_d;
  logic [7:0]       alu_cins_q, alu_cins_d, alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic             wb_valid_q, wb_valid_d;
  logic [1:0]       wb_dst_q, wb_dst_d;
  logic [7:0]       wb_data_q, wb_data_d;
  logic             flag_c_q, flag_c_d, flag_v_q, flag_v_d, flag_z_q, flag_z_d;
  logic             flag_n_q, flag_n_d, flag_cmp_q, flag_cmp_d;
  logic             err_q, err_d;
  logic             busy_d;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    dst_d       = dst_q;
    wb_d        = wb_q;
    cnt_d       = cnt_q;
    cnt_inc     = cnt_q + CNT_W'(1);
    cmp_seen_d  = cmp_seen_q;
    wb_valid_d  = 1'b0;
    wb_dst_d    = wb_dst_q;
    wb_data_d   = wb_data_q;
    flag_c_d    = flag_c_q;
    flag_v_d    = flag_v_q;
    flag_z_d    = flag_z_q;
    flag_n_d    = flag_n_q;
    flag_cmp_d  = flag_cmp_q;
    err_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          dst_d   = req_dst;
          wb_d    = req_wb;
          state_d = (req_op >= 8'h51 && req_op <= 8'h54) ? S_MODE : S_START;
        end
      end
      S_MODE:   state_d = S_SETTLE;
      S_SETTLE: state_d = S_IDLE;
      S_START: begin
        cnt_d      = '0;
        cmp_seen_d = 1'b0;
        state_d    = S_WAIT_LO;
      end
      S_WAIT_LO, S_WAIT_HI: begin
        cmp_seen_d = cmp_seen_q | alu_cmpo;
        cnt_d      = cnt_inc;
        if (state_q == S_WAIT_LO && !alu_done) begin
          state_d = S_WAIT_HI;
        end else if (state_q == S_WAIT_HI && alu_done) begin
          // Result is sampled on the edge that enters CAPTURE so wb/flags appear during CAPTURE.
          state_d    = S_CAPTURE;
          wb_valid_d = wb_q;
          wb_dst_d   = dst_q;
          wb_data_d  = alu_out;
          flag_c_d   = alu_carryout;
          flag_v_d   = alu_overout;
          flag_z_d   = (alu_out == 8'h00);
          flag_n_d   = alu_out[7];
          if (cmp_seen_d) begin
            flag_cmp_d = (op_q == CMP_CLR_OP) ? 1'b0 : alu_carryout;
          end
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Handshake outputs are registered versions of the next-state decode.
    busy_d      = state_d inside {S_START, S_WAIT_LO, S_WAIT_HI, S_CAPTURE};
    req_ready_d = (state_d == S_IDLE);
    alu_start_d = (state_d == S_START);
    alu_oe_d    = (state_d == S_WAIT_HI);
    alu_cins_d  = (busy_d || state_d == S_MODE) ? op_d : NOP_OP;
    alu_a_d     = busy_d ? a_d : 8'h00;
    alu_b_d     = busy_d ? b_d : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= 8'h00;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      dst_q       <= 2'd0;
      wb_q        <= 1'b0;
      cnt_q       <= '0;
      cmp_seen_q  <= 1'b0;
      req_ready_q <= 1'b1;
      alu_start_q <= 1'b0;
      alu_oe_q    <= 1'b0;
      alu_cins_q  <= NOP_OP;
      alu_a_q     <= 8'h00;
      alu_b_q     <= 8'h00;
      wb_valid_q  <= 1'b0;
      wb_dst_q    <= 2'd0;
      wb_data_q   <= 8'h00;
      flag_c_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_n_q    <= 1'b0;
      flag_cmp_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      dst_q       <= dst_d;
      wb_q        <= wb_d;
      cnt_q       <= cnt_d;
      cmp_seen_q  <= cmp_seen_d;
      req_ready_q <= req_ready_d;
      alu_start_q <= alu_start_d;
      alu_oe_q    <= alu_oe_d;
      alu_cins_q  <= alu_cins_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      wb_valid_q  <= wb_valid_d;
      wb_dst_q    <= wb_dst_d;
      wb_data_q   <= wb_data_d;
      flag_c_q    <= flag_c_d;
      flag_v_q    <= flag_v_d;
      flag_z_q    <= flag_z_d;
      flag_n_q    <= flag_n_d;
      flag_cmp_q  <= flag_cmp_d;
      err_q       <= err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign alu_start   = alu_start_q;
  assign alu_oe      = alu_oe_q;
  assign alu_cins    = alu_cins_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_carryin = flag_c_q;
  assign wb_valid    = wb_valid_q;
  assign wb_dst      = wb_dst_q;
  assign wb_data     = wb_data_q;
  assign flag_c      = flag_c_q;
  assign flag_v      = flag_v_q;
  assign flag_z      = flag_z_q;
  assign flag_n      = flag_n_q;
  assign flag_cmp    = flag_cmp_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU responder (done low 6 cycles after start).
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_wb;
  logic [7:0] req_op, req_a, req_b;
  logic [1:0] req_dst;
  logic       alu_start, alu_oe, alu_carryin;
  logic [7:0] alu_cins, alu_a, alu_b;
  logic       alu_done, alu_carryout, alu_overout, alu_cmpo;
  logic [7:0] alu_out;
  logic       wb_valid;
  logic [1:0] wb_dst;
  logic [7:0] wb_data;
  logic       flag_c, flag_v, flag_z, flag_n, flag_cmp, err_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  bit hang     = 1'b0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a),
    .req_b(req_b), .req_dst(req_dst), .req_wb(req_wb),
    .alu_start(alu_start), .alu_cins(alu_cins), .alu_a(alu_a), .alu_b(alu_b),
    .alu_oe(alu_oe), .alu_carryin(alu_carryin), .alu_done(alu_done), .alu_out(alu_out),
    .alu_carryout(alu_carryout), .alu_overout(alu_overout), .alu_cmpo(alu_cmpo),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n),
    .flag_cmp(flag_cmp), .err_timeout(err_timeout)
  );

  // ALU model result: {cmpo, overflow, carry, out}
  function automatic logic [10:0] alu_f(input logic [7:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    logic [8:0] s;
    case (op)
      8'h01: begin
        s = {1'b0, a} + {1'b0, b};
        return {1'b0, (a[7] == b[7]) && (s[7] != a[7]), s[8], s[7:0]};
      end
      8'h10, 8'h50: return {1'b1, 1'b0, (a >= b), 8'(a - b)};
      default:      return {3'b000, a ^ b};
    endcase
  endfunction

  int         m_cnt;
  bit         m_busy;
  logic [7:0] m_op, m_a, m_b;
  logic [10:0] m_res;
  assign m_res = alu_f(m_op, m_a, m_b);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_done <= 1'b1; alu_out <= 8'h00; alu_carryout <= 1'b0;
      alu_overout <= 1'b0; alu_cmpo <= 1'b0; m_busy <= 1'b0; m_cnt <= 0;
      m_op <= 8'h00; m_a <= 8'h00; m_b <= 8'h00;
    end else if (alu_start) begin
      alu_done <= 1'b0; alu_cmpo <= 1'b0; m_busy <= 1'b1; m_cnt <= 5;
      m_op <= alu_cins; m_a <= alu_a; m_b <= alu_b;
    end else if (m_busy && !hang) begin
      if (m_cnt == 0) begin
        alu_done <= 1'b1; m_busy <= 1'b0;
        alu_out <= m_res[7:0]; alu_carryout <= m_res[8];
        alu_overout <= m_res[9]; alu_cmpo <= m_res[10];
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else begin
      alu_cmpo <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] op; logic [7:0] a; logic [7:0] b; logic [1:0] dst; logic wb;
    logic mode; logic cin; logic [7:0] data;
    logic c; logic v; logic z; logic n; logic cmp;
  } vec_t;

  task automatic drive_req(input vec_t v);
    @(negedge clk);
    check("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b; req_dst = v.dst; req_wb = v.wb;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int wb_cnt = 0, wb_cyc = -1, rdy_cyc = -1, start_cnt = 0;
    drive_req(v);
    for (int cyc = 1; cyc <= 30 && rdy_cyc < 0; cyc++) begin
      @(negedge clk);
      if (alu_start) start_cnt++;
      if (cyc == 1) begin
        check("cins_c1", 32'(alu_cins), 32'(v.op));
        check("carryin_c1", 32'(alu_carryin), 32'(v.cin));
      end
      if (cyc == 2 && v.mode) check("cins_settle", 32'(alu_cins), 32'h00);
      if (cyc == 3 && !v.mode) begin
        check("alu_a_hold", 32'(alu_a), 32'(v.a));
        check("alu_oe", 32'(alu_oe), 32'd1);
      end
      if (wb_valid) begin
        wb_cnt++; wb_cyc = cyc;
        check("wb_data", 32'(wb_data), 32'(v.data));
        check("wb_dst", 32'(wb_dst), 32'(v.dst));
      end
      if (req_ready) rdy_cyc = cyc;
    end
    check("ready_return_cycle", 32'(rdy_cyc), v.mode ? 32'd3 : 32'd10);
    check("start_pulses", 32'(start_cnt), v.mode ? 32'd0 : 32'd1);
    check("wb_count", 32'(wb_cnt), (!v.mode && v.wb) ? 32'd1 : 32'd0);
    if (!v.mode && v.wb) check("wb_cycle", 32'(wb_cyc), 32'd9);
    check("flags_cvznp", {27'd0, flag_c, flag_v, flag_z, flag_n, flag_cmp},
          {27'd0, v.c, v.v, v.z, v.n, v.cmp});
  endtask

  vec_t vecs[11];

  initial begin
    //            op     a      b      dst wb mode cin data   c v z n cmp
    vecs[0]  = '{8'h01, 8'h7F, 8'h01, 2'd2, 1, 0, 0, 8'h80, 0, 1, 0, 1, 0};
    vecs[1]  = '{8'h01, 8'hFF, 8'h01, 2'd1, 1, 0, 0, 8'h00, 1, 0, 1, 0, 0};
    vecs[2]  = '{8'h01, 8'h10, 8'h20, 2'd3, 0, 0, 1, 8'h30, 0, 0, 0, 0, 0};
    vecs[3]  = '{8'h10, 8'h05, 8'h03, 2'd0, 0, 0, 0, 8'h02, 1, 0, 0, 0, 1};
    vecs[4]  = '{8'h50, 8'h09, 8'h02, 2'd0, 0, 0, 1, 8'h07, 1, 0, 0, 0, 0};
    vecs[5]  = '{8'h10, 8'h08, 8'h08, 2'd0, 1, 0, 1, 8'h00, 1, 0, 1, 0, 1};
    vecs[6]  = '{8'h01, 8'h80, 8'h80, 2'd3, 1, 0, 1, 8'h00, 1, 1, 1, 0, 1};
    vecs[7]  = '{8'h52, 8'h11, 8'h22, 2'd1, 1, 1, 1, 8'h00, 1, 1, 1, 0, 1};
    vecs[8]  = '{8'h54, 8'h00, 8'h00, 2'd1, 1, 1, 1, 8'h00, 1, 1, 1, 0, 1};
    vecs[9]  = '{8'h55, 8'hF0, 8'h0F, 2'd1, 1, 0, 1, 8'hFF, 0, 0, 0, 1, 1};
    vecs[10] = '{8'h51, 8'h00, 8'h00, 2'd0, 1, 1, 0, 8'h00, 0, 0, 0, 1, 1};

    rst = 1'b1; req_valid = 1'b0; req_op = 8'h00; req_a = 8'h00; req_b = 8'h00;
    req_dst = 2'd0; req_wb = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_cins", 32'(alu_cins), 32'h00);
    check("rst_outs", {24'd0, alu_start, alu_oe, wb_valid, err_timeout, flag_c, flag_v, flag_z,
          flag_cmp}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // ALU never raises done: abort after 16 wait cycles, flags untouched.
    begin
      vec_t t;
      int err_cnt = 0, err_cyc = -1, rdy_cyc = -1, wb_cnt = 0;
      t = '{8'h01, 8'h01, 8'h01, 2'd1, 1, 0, 0, 8'h00, 0, 0, 0, 1, 1};
      hang = 1'b1;
      drive_req(t);
      for (int cyc = 1; cyc <= 22; cyc++) begin
        @(negedge clk);
        if (err_timeout) begin err_cnt++; err_cyc = cyc; end
        if (wb_valid) wb_cnt++;
        if (req_ready && rdy_cyc < 0) rdy_cyc = cyc;
      end
      check("to_err_count", 32'(err_cnt), 32'd1);
      check("to_err_cycle", 32'(err_cyc), 32'd18);
      check("to_ready_cycle", 32'(rdy_cyc), 32'd18);
      check("to_no_wb", 32'(wb_cnt), 32'd0);
      check("to_flags", {27'd0, flag_c, flag_v, flag_z, flag_n, flag_cmp}, 32'b00011);
      hang = 1'b0;
      repeat (10) @(negedge clk);
    end

    // Reset in cycle 5 of an op, then a fresh op completes normally.
    begin
      vec_t t;
      int wb_cnt = 0;
      t = '{8'h01, 8'h01, 8'h02, 2'd2, 1, 0, 0, 8'h03, 0, 0, 0, 0, 0};
      drive_req(t);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_ready", 32'(req_ready), 32'd1);
      check("mid_rst_cins", 32'(alu_cins), 32'h00);
      check("mid_rst_outs", {24'd0, alu_start, alu_oe, wb_valid, flag_c, flag_v, flag_z, flag_n,
            flag_cmp}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int cyc = 0; cyc < 12; cyc++) begin
        @(negedge clk);
        if (wb_valid) wb_cnt++;
      end
      check("mid_rst_no_wb", 32'(wb_cnt), 32'd0);
      run_vec(t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
